fp_add_mant_norm: RTL and testbench
===================================

# fp_add_mant_norm

Two-stage pipelined result-select and normalization stage of the floating-point adder, directly downstream of the high-part incrementer. It takes the compound high sums (plain and inverted) plus the matching low-part sums, selects the true magnitude, and counts leading zeros. It then left-normalizes, adjusts the exponent and produces a rounding-ready mantissa with sticky. Valid/ready handshake on both sides; full throughput.

## Interface
- PARM_MANT, 23: fraction width; high part is PARM_MANT+4 bits.
- PARM_EXP, 8: exponent width.
- PARM_LOW, 24: low-part width; full magnitude width W = PARM_MANT+4+PARM_LOW.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  stage can accept a beat.
- high_sum_i  in  PARM_MANT+4  high part, non-inverted path.
- high_sum_inv_i  in  PARM_MANT+4  high part, inverted path.
- low_sum_i / low_sum_inv_i  in  PARM_LOW  matching low parts.
- sel_inv_i  in  1  1 = result negative, use the inverted path.
- sign_i  in  1  sign of the larger operand.
- exp_i  in  PARM_EXP  exponent, referenced to bit W-2 (bit W-1 is the carry guard).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- mant_o  out  PARM_MANT+4  normalized mantissa, MSB = leading 1.
- sticky_o  out  1  OR of the PARM_LOW bits shifted out below mant_o.
- exp_o  out  PARM_EXP  adjusted exponent.
- sign_o  out  1  result sign.
- zero_o, tiny_o, ovf_o  out  1 each  exact zero, denormal/underflow, exponent overflow.

## Operation
- S1 (select): mag = sel_inv_i ? {high_sum_inv_i, low_sum_inv_i} : {high_sum_i, low_sum_i}. sgn = sign_i ^ sel_inv_i. Register mag, sgn and exp_i.
- S2 (normalize): lzc = leading zeros of mag (0..W).
  - mag == 0: zero_o=1, mant_o=0, sticky_o=0, exp_o=0, sign_o=0 (+0).
  - lzc <= exp: shift = lzc, exp_o = exp+1-lzc.
  - lzc > exp: shift = exp, exp_o = 0, tiny_o = 1.
  - Exponent arithmetic is PARM_EXP+1 bits wide. If the result is at least 2^PARM_EXP-1: ovf_o=1 and exp_o=all-ones.
  - shifted = mag << shift. mant_o = shifted[W-1 -: PARM_MANT+4]. sticky_o = |shifted[PARM_LOW-1:0].
- The S2 result is registered into the output register. Flags are mutually exclusive except tiny_o with a non-zero mantissa.

## Timing
- Latency: 2 cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o, with no stalls.
- Output register advances when !out_valid_o || out_ready_i.
- S1 advances when !s1_valid || (output register advances).
- in_ready_o = !s1_valid || (output register advances). This is a combinational ready path.
- Once asserted, out_valid_o and all data outputs hold stable until out_ready_i.
- Simultaneous accept and drain in the same cycle gives a full-rate pass-through.
- Capacity is 2 beats. With out_ready_i low, in_ready_o drops after 2 beats are held.
- Reset (async, any time, including mid-stream):
  - All valids clear and every output goes to 0.
  - in_ready_o = 1 after reset.
  - In-flight beats are discarded.

## Structure
- Shared package fp_add_pkg holds:
  - constants W and LZC_W = clog2(W+1);
  - the default PARM_MANT, PARM_EXP and PARM_LOW values;
  - a struct for the S1 payload {mag, sgn, exp}.
- Sub-module fp_lzc: a purely combinational leading-zero counter over W bits with a parameterized width. It outputs the count and an all-zero flag.

## Test plan
Defaults for all scenarios: PARM_MANT=23, PARM_LOW=24, W=51.
- high=27'h4000000, low=0, sel_inv=0, exp=100, sign=0 -> after 2 cycles: mant_o=27'h4000000, exp_o=101, sticky_o=0, all flags 0.
- high=27'h0000001, low=24'h800000, sel_inv=0, exp=100 -> lzc=26, mant_o=27'h6000000, exp_o=75, sticky_o=0.
- high=27'h4000000, low=24'h000001 -> mant_o=27'h4000000, sticky_o=1.
- sel_inv=1, sign=0, high_inv=0, low_inv=0 -> zero_o=1, sign_o=0, exp_o=0, mant_o=0. The same input with sel_inv=1 and non-zero data gives sign_o=1.
- high=0, low=24'h000001, exp=10 -> tiny_o=1, exp_o=0, shift 10, mant_o=0, sticky_o=1.
- Backpressure, reset and overflow:
  - 4 back-to-back beats with out_ready_i low for 4 cycles -> in_ready_o low after 2 beats; all 4 results delivered in order with no loss or duplication.
  - rst_n_i pulsed mid-stream -> outputs 0 immediately; no stale beat appears afterward.
  - exp=254 with a carry-set input -> ovf_o=1, exp_o=8'hFF.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared constants and payload types for the FP adder mantissa normalization stage.
package fp_add_pkg;

    localparam int FP_MANT = 23;
    localparam int FP_EXP  = 8;
    localparam int FP_LOW  = 24;

    // Full magnitude width: high part (fraction + 4 guard/carry bits) plus low part.
    localparam int W     = FP_MANT + 4 + FP_LOW;
    localparam int LZC_W = $clog2(W + 1);

    // Payload held in the select stage register.
    typedef struct packed {
        logic [W-1:0]      mag;
        logic              sgn;
        logic [FP_EXP-1:0] exp;
    } s1_payload_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; count is WIDTH when the vector is all zero.
module fp_lzc #(
    parameter int WIDTH = 51,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    // Scan from LSB upward so the highest set bit determines the final count.
    always_comb begin
        cnt_o  = CNT_W'(WIDTH);
        zero_o = ~|vec_i;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_mant_norm.sv
// Result select (S1) and leading-zero normalization (S2) of the FP adder,
// two-entry valid/ready pipeline with full throughput.
module fp_add_mant_norm
    import fp_add_pkg::*;
#(
    parameter int PARM_MANT = FP_MANT,
    parameter int PARM_EXP  = FP_EXP,
    parameter int PARM_LOW  = FP_LOW
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [PARM_MANT+3:0]   high_sum_i,
    input  logic [PARM_MANT+3:0]   high_sum_inv_i,
    input  logic [PARM_LOW-1:0]    low_sum_i,
    input  logic [PARM_LOW-1:0]    low_sum_inv_i,
    input  logic                   sel_inv_i,
    input  logic                   sign_i,
    input  logic [PARM_EXP-1:0]    exp_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [PARM_MANT+3:0]   mant_o,
    output logic                   sticky_o,
    output logic [PARM_EXP-1:0]    exp_o,
    output logic                   sign_o,
    output logic                   zero_o,
    output logic                   tiny_o,
    output logic                   ovf_o
);

    localparam int MW    = PARM_MANT + 4;
    localparam int MAG_W = MW + PARM_LOW;
    localparam int E1    = PARM_EXP + 1;
    localparam int CMP_W = (LZC_W > E1) ? LZC_W : E1;

    s1_payload_t       s1_q;
    logic              s1_valid;
    logic              out_adv;
    logic              s1_adv;

    logic [LZC_W-1:0]  lzc;
    logic              lzc_zero;
    logic [CMP_W-1:0]  lzc_c;
    logic [CMP_W-1:0]  exp_c;
    logic [LZC_W-1:0]  shift;
    logic [E1-1:0]     exp_sum;
    logic [MAG_W-1:0]  shifted;

    logic [MW-1:0]       n_mant;
    logic                n_sticky;
    logic [PARM_EXP-1:0] n_exp;
    logic                n_sign;
    logic                n_zero;
    logic                n_tiny;
    logic                n_ovf;

    // Handshake: output register drains or is empty; S1 moves when it can hand off.
    always_comb begin
        out_adv    = !out_valid_o || out_ready_i;
        s1_adv     = !s1_valid || out_adv;
        in_ready_o = s1_adv;
    end

    // S1: pick the true magnitude path and fold the path choice into the sign.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_q.mag <= sel_inv_i ? {high_sum_inv_i, low_sum_inv_i}
                                      : {high_sum_i, low_sum_i};
                s1_q.sgn <= sign_i ^ sel_inv_i;
                s1_q.exp <= exp_i;
            end
        end
    end

    fp_lzc #(
        .WIDTH(MAG_W),
        .CNT_W(LZC_W)
    ) u_lzc (
        .vec_i (s1_q.mag),
        .cnt_o (lzc),
        .zero_o(lzc_zero)
    );

    // S2: clamp the shift at the exponent (denormal), adjust exponent, saturate on overflow.
    always_comb begin
        lzc_c    = CMP_W'(lzc);
        exp_c    = CMP_W'(s1_q.exp);
        shift    = lzc;
        exp_sum  = '0;
        n_exp    = '0;
        n_tiny   = 1'b0;
        n_ovf    = 1'b0;
        n_zero   = 1'b0;
        n_sign   = s1_q.sgn;
        if (lzc_c <= exp_c) begin
            shift   = lzc;
            exp_sum = E1'(s1_q.exp) + E1'(1) - E1'(lzc);
            if (exp_sum >= {1'b0, {PARM_EXP{1'b1}}}) begin
                n_ovf = 1'b1;
                n_exp = '1;
            end else begin
                n_exp = exp_sum[PARM_EXP-1:0];
            end
        end else begin
            // exp < lzc <= MAG_W here, so the exponent fits the shift width.
            shift  = LZC_W'(s1_q.exp);
            n_tiny = 1'b1;
        end
        shifted  = s1_q.mag << shift;
        n_mant   = shifted[MAG_W-1 -: MW];
        n_sticky = |shifted[PARM_LOW-1:0];
        if (lzc_zero) begin
            n_mant   = '0;
            n_sticky = 1'b0;
            n_exp    = '0;
            n_sign   = 1'b0;
            n_zero   = 1'b1;
            n_tiny   = 1'b0;
            n_ovf    = 1'b0;
        end
    end

    // Output register: holds the result stable until the consumer accepts it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            mant_o      <= '0;
            sticky_o    <= 1'b0;
            exp_o       <= '0;
            sign_o      <= 1'b0;
            zero_o      <= 1'b0;
            tiny_o      <= 1'b0;
            ovf_o       <= 1'b0;
        end else if (out_adv) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                mant_o   <= n_mant;
                sticky_o <= n_sticky;
                exp_o    <= n_exp;
                sign_o   <= n_sign;
                zero_o   <= n_zero;
                tiny_o   <= n_tiny;
                ovf_o    <= n_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_mant_norm.sv
// Directed self-checking bench for fp_add_mant_norm (default parameters).
module tb_fp_add_mant_norm;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [26:0] high_sum_i;
    logic [26:0] high_sum_inv_i;
    logic [23:0] low_sum_i;
    logic [23:0] low_sum_inv_i;
    logic        sel_inv_i;
    logic        sign_i;
    logic [7:0]  exp_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [26:0] mant_o;
    logic        sticky_o;
    logic [7:0]  exp_o;
    logic        sign_o;
    logic        zero_o;
    logic        tiny_o;
    logic        ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic       mon_en = 1'b0;
    logic [7:0] got_exp[$];

    fp_add_mant_norm #(
        .PARM_MANT(23),
        .PARM_EXP (8),
        .PARM_LOW (24)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .high_sum_i    (high_sum_i),
        .high_sum_inv_i(high_sum_inv_i),
        .low_sum_i     (low_sum_i),
        .low_sum_inv_i (low_sum_inv_i),
        .sel_inv_i     (sel_inv_i),
        .sign_i        (sign_i),
        .exp_i         (exp_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .mant_o        (mant_o),
        .sticky_o      (sticky_o),
        .exp_o         (exp_o),
        .sign_o        (sign_o),
        .zero_o        (zero_o),
        .tiny_o        (tiny_o),
        .ovf_o         (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every completed output handshake (sampled mid-cycle, before the edge).
    always @(negedge clk_i) begin
        if (mon_en && rst_n_i && out_valid_o && out_ready_i) begin
            got_exp.push_back(exp_o);
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Present one beat and hold it until the stage accepts it.
    task automatic send_beat(input logic [26:0] hi, input logic [26:0] hi_inv,
                             input logic [23:0] lo, input logic [23:0] lo_inv,
                             input logic sel, input logic sg, input logic [7:0] ex);
        logic acc;
        high_sum_i     = hi;
        high_sum_inv_i = hi_inv;
        low_sum_i      = lo;
        low_sum_inv_i  = lo_inv;
        sel_inv_i      = sel;
        sign_i         = sg;
        exp_i          = ex;
        in_valid_i     = 1'b1;
        acc            = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                @(posedge clk_i);
                #1;
                acc = 1'b1;
            end
        end
        in_valid_i = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    // Wait for the result of the beat just sent and compare every output field.
    task automatic expect_result(input string tag, input logic [26:0] e_mant,
                                 input logic e_sticky, input logic [7:0] e_exp,
                                 input logic e_sign, input logic e_zero,
                                 input logic e_tiny, input logic e_ovf);
        int cyc;
        cyc = 0;
        while (!out_valid_o && cyc < 10) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc),      64'd1);
        chk({tag, ".mant"},    64'(mant_o),   64'(e_mant));
        chk({tag, ".sticky"},  64'(sticky_o), 64'(e_sticky));
        chk({tag, ".exp"},     64'(exp_o),    64'(e_exp));
        chk({tag, ".sign"},    64'(sign_o),   64'(e_sign));
        chk({tag, ".zero"},    64'(zero_o),   64'(e_zero));
        chk({tag, ".tiny"},    64'(tiny_o),   64'(e_tiny));
        chk({tag, ".ovf"},     64'(ovf_o),    64'(e_ovf));
    endtask

    initial begin
        int cyc;
        rst_n_i        = 1'b0;
        in_valid_i     = 1'b0;
        out_ready_i    = 1'b1;
        high_sum_i     = '0;
        high_sum_inv_i = '0;
        low_sum_i      = '0;
        low_sum_inv_i  = '0;
        sel_inv_i      = 1'b0;
        sign_i         = 1'b0;
        exp_i          = '0;

        // Reset state
        #12;
        chk("rst.out_valid", 64'(out_valid_o), 64'd0);
        chk("rst.in_ready",  64'(in_ready_o),  64'd1);
        chk("rst.mant",      64'(mant_o),      64'd0);
        chk("rst.exp",       64'(exp_o),       64'd0);
        chk("rst.flags",     64'({sticky_o, sign_o, zero_o, tiny_o, ovf_o}), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Already normalized, carry-guard bit set: exp+1
        send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b0, 8'd100);
        expect_result("norm", 27'h4000000, 1'b0, 8'd101, 1'b0, 1'b0, 1'b0, 1'b0);

        // lzc=26: two bits straddling the high/low boundary
        send_beat(27'h0000001, 27'h0, 24'h800000, 24'h0, 1'b0, 1'b0, 8'd100);
        expect_result("lzc26", 27'h6000000, 1'b0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sticky from the LSB of the low part
        send_beat(27'h4000000, 27'h0, 24'h000001, 24'h0, 1'b0, 1'b0, 8'd100);
        expect_result("sticky", 27'h4000000, 1'b1, 8'd101, 1'b0, 1'b0, 1'b0, 1'b0);

        // Inverted path all-zero: +0 even though the plain path is non-zero
        send_beat(27'h7FFFFFF, 27'h0, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 8'd100);
        expect_result("zero", 27'h0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Inverted path non-zero: sign flips, lzc=3 -> exp 98
        send_beat(27'h0, 27'h0800000, 24'h0, 24'h0, 1'b1, 1'b0, 8'd100);
        expect_result("inv", 27'h4000000, 1'b0, 8'd98, 1'b1, 1'b0, 1'b0, 1'b0);

        // Underflow: shift clamped at exp=10, bit stays in the sticky region
        send_beat(27'h0, 27'h0, 24'h000001, 24'h0, 1'b0, 1'b0, 8'd10);
        expect_result("tiny", 27'h0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Boundary lzc == exp: full shift, exp_o = 1, not tiny
        send_beat(27'h0000001, 27'h0, 24'h0, 24'h0, 1'b0, 1'b1, 8'd26);
        expect_result("lzc_eq_exp", 27'h4000000, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Largest non-overflowing exponent
        send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b0, 8'd253);
        expect_result("exp254", 27'h4000000, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overflow: 254+1 saturates
        send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b0, 8'd254);
        expect_result("ovf", 27'h4000000, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: four beats, consumer stalled for four cycles
        @(posedge clk_i);
        #1;
        got_exp.delete();
        mon_en      = 1'b1;
        out_ready_i = 1'b0;
        fork
            begin
                for (int b = 1; b <= 4; b++) begin
                    send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b0, 8'(b));
                end
            end
            begin
                repeat (2) @(posedge clk_i);
                #2;
                chk("bp.ready_full", 64'(in_ready_o), 64'd0);
                repeat (2) @(posedge clk_i);
                #2;
                chk("bp.hold_valid", 64'(out_valid_o), 64'd1);
                chk("bp.hold_exp",   64'(exp_o),       64'd2);
                chk("bp.ready_held", 64'(in_ready_o),  64'd0);
                out_ready_i = 1'b1;
            end
        join
        cyc = 0;
        while (got_exp.size() < 4 && cyc < 30) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk("bp.count", 64'(got_exp.size()), 64'd4);
        for (int b = 0; b < 4; b++) begin
            if (b < got_exp.size()) chk($sformatf("bp.order%0d", b), 64'(got_exp[b]), 64'(b + 2));
        end

        // Reset mid-stream with two beats in flight
        got_exp.delete();
        out_ready_i = 1'b0;
        send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b1, 8'd50);
        send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b1, 8'd60);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("mrst.out_valid", 64'(out_valid_o), 64'd0);
        chk("mrst.exp",       64'(exp_o),       64'd0);
        chk("mrst.mant",      64'(mant_o),      64'd0);
        chk("mrst.sign",      64'(sign_o),      64'd0);
        chk("mrst.in_ready",  64'(in_ready_o),  64'd1);
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        out_ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("mrst.no_stale", 64'(got_exp.size()), 64'd0);
        send_beat(27'h4000000, 27'h0, 24'h0, 24'h0, 1'b0, 1'b0, 8'd70);
        repeat (4) @(posedge clk_i);
        #1;
        chk("mrst.fresh_count", 64'(got_exp.size()), 64'd1);
        if (got_exp.size() > 0) chk("mrst.fresh_exp", 64'(got_exp[0]), 64'd71);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
